// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, signed or unsigned.
// Results and the divide-by-zero flag are held until the next done pulse.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] dvd_reg;      // dividend magnitude, quotient bits shift in at the LSB
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;

    logic             accept;
    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial_diff;
    logic             trial_neg;
    logic [WIDTH-1:0] rem_next;

    assign accept  = start && (state_reg == IDLE || state_reg == DONE);
    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dsr_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dsr_mag = dsr_neg ? -divisor : divisor;

    // The partial remainder stays below the divisor, so the shifted value minus
    // the divisor always fits in WIDTH+1 bits and its top bit is the sign.
    assign shifted    = {rem_reg, dvd_reg[WIDTH-1]};
    assign trial_diff = shifted - {1'b0, dsr_reg};
    assign trial_neg  = trial_diff[WIDTH];
    assign rem_next   = trial_neg ? shifted[WIDTH-1:0] : trial_diff[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC:    state_next = (count_reg == '0) ? FIX : CALC;
            FIX:     state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == CALC) || (state_reg == FIX);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg   <= '0;
            dvd_reg     <= '0;
            dsr_reg     <= '0;
            rem_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else if (accept) begin
            count_reg <= CW'(WIDTH - 1);
            dvd_reg   <= dvd_mag;
            dsr_reg   <= dsr_mag;
            rem_reg   <= '0;
            q_neg_reg <= dvd_neg ^ dsr_neg;
            r_neg_reg <= dvd_neg;
            if (divisor == '0) begin
                div_by_zero <= 1'b1;
                quotient    <= '1;
                remainder   <= dividend;
            end
        end else if (state_reg == CALC) begin
            rem_reg <= rem_next;
            dvd_reg <= {dvd_reg[WIDTH-2:0], ~trial_neg};
            if (count_reg != '0) begin
                count_reg <= count_reg - CW'(1);
            end
        end else if (state_reg == FIX) begin
            div_by_zero <= 1'b0;
            quotient    <= q_neg_reg ? -dvd_reg : dvd_reg;
            remainder   <= r_neg_reg ? -rem_reg : rem_reg;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed checks of seq_divider at WIDTH=32 and WIDTH=8: results, latency,
// busy/done timing, start-while-busy, back-to-back operation and reset abort.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset32, start32, sgn32;
    logic [31:0] a32, b32;
    logic        busy32, done32, dz32;
    logic [31:0] q32, r32;

    logic        reset8, start8, sgn8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dz8;
    logic [7:0]  q8, r8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset32), .start(start32), .is_signed(sgn32),
        .dividend(a32), .divisor(b32), .busy(busy32), .done(done32),
        .div_by_zero(dz32), .quotient(q32), .remainder(r32)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .is_signed(sgn8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .div_by_zero(dz8), .quotient(q8), .remainder(r8)
    );

    typedef struct {
        bit          w8;
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic get_out(input bit w8, output logic d, output logic b,
                           output logic [31:0] q, output logic [31:0] r, output logic z);
        if (w8) begin
            d = done8; b = busy8; q = {24'h0, q8}; r = {24'h0, r8}; z = dz8;
        end else begin
            d = done32; b = busy32; q = q32; r = r32; z = dz32;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one operation and returns the cycle count from the start-sampling edge to done.
    task automatic run_op(input vec_t v);
        int n, bcnt, lat;
        logic d, b, z;
        logic [31:0] q, r;
        if (v.w8) begin
            a8 = v.a[7:0]; b8 = v.b[7:0]; sgn8 = v.sgn; start8 = 1'b1;
        end else begin
            a32 = v.a; b32 = v.b; sgn32 = v.sgn; start32 = 1'b1;
        end
        tick();
        start8 = 1'b0; start32 = 1'b0;
        n = 1; bcnt = 0;
        get_out(v.w8, d, b, q, r, z);
        while (!d && n < 200) begin
            if (b) bcnt++;
            tick();
            n++;
            get_out(v.w8, d, b, q, r, z);
        end
        lat = v.dz ? 1 : (v.w8 ? 10 : 34);
        $display("op w8=%0d s=%0d a=%h b=%h -> q=%h r=%h dz=%b lat=%0d",
                 v.w8, v.sgn, v.a, v.b, q, r, z, n);
        chk("done_seen", 64'(d), 64'(1));
        chk("latency", 64'(n), 64'(lat));
        chk("busy_cycles", 64'(bcnt), 64'(lat - 1));
        chk("busy_at_done", 64'(b), 64'(0));
        chk("quotient", 64'(q), 64'(v.q));
        chk("remainder", 64'(r), 64'(v.r));
        chk("div_by_zero", 64'(z), 64'(v.dz));
        tick();
        get_out(v.w8, d, b, q, r, z);
        chk("done_one_cycle", 64'(d), 64'(0));
        chk("q_held", 64'(q), 64'(v.q));
    endtask

    initial begin
        int n;
        int seen;
        logic d, b, z;
        logic [31:0] q, r;

        vecs[0]  = '{0, 0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{0, 1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[2]  = '{0, 1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
        vecs[3]  = '{0, 0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
        vecs[4]  = '{0, 1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
        vecs[5]  = '{0, 1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vecs[6]  = '{0, 0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
        vecs[7]  = '{0, 1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
        vecs[8]  = '{0, 0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
        vecs[9]  = '{0, 0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0};
        vecs[10] = '{1, 0, 32'hFF,         32'h01,         32'hFF,         32'h00,         1'b0};
        vecs[11] = '{1, 1, 32'h80,         32'h03,         32'hD6,         32'hFE,         1'b0};
        vecs[12] = '{1, 1, 32'h80,         32'hFF,         32'h80,         32'h00,         1'b0};
        vecs[13] = '{1, 0, 32'h80,         32'h00,         32'hFF,         32'h80,         1'b1};

        reset32 = 1'b1; reset8 = 1'b1;
        start32 = 1'b0; start8 = 1'b0; sgn32 = 1'b0; sgn8 = 1'b0;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        tick();
        tick();
        chk("rst32_busy", 64'(busy32), 64'(0));
        chk("rst32_done", 64'(done32), 64'(0));
        chk("rst32_dz", 64'(dz32), 64'(0));
        chk("rst32_q", 64'(q32), 64'(0));
        chk("rst32_r", 64'(r32), 64'(0));
        chk("rst8_q", 64'(q8), 64'(0));
        reset32 = 1'b0; reset8 = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i]);
        end

        // Start while busy is ignored; start held in the done cycle runs back-to-back.
        a32 = 32'd50; b32 = 32'd5; sgn32 = 1'b0; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        n = 1;
        while (!done32 && n < 200) begin
            if (n == 10) begin
                a32 = 32'd9; b32 = 32'd3; start32 = 1'b1;
            end else begin
                start32 = 1'b0;
            end
            tick();
            n++;
        end
        $display("op busy-start 50/5 -> q=%h r=%h lat=%0d", q32, r32, n);
        chk("ign_latency", 64'(n), 64'(34));
        chk("ign_q", 64'(q32), 64'(10));
        chk("ign_r", 64'(r32), 64'(0));
        a32 = 32'd9; b32 = 32'd3; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        chk("b2b_busy_no_gap", 64'(busy32), 64'(1));
        n = 1;
        while (!done32 && n < 200) begin
            tick();
            n++;
        end
        $display("op back-to-back 9/3 -> q=%h r=%h lat=%0d", q32, r32, n);
        chk("b2b_latency", 64'(n), 64'(34));
        chk("b2b_q", 64'(q32), 64'(3));
        chk("b2b_r", 64'(r32), 64'(0));

        // Reset in the middle of an 8-bit operation aborts it silently.
        a8 = 8'hFF; b8 = 8'h01; sgn8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 1; i < 4; i++) tick();
        reset8 = 1'b1;
        tick();
        get_out(1'b1, d, b, q, r, z);
        $display("op reset-abort w8 -> busy=%b done=%b q=%h r=%h dz=%b", b, d, q, r, z);
        chk("abort_busy", 64'(b), 64'(0));
        chk("abort_done", 64'(d), 64'(0));
        chk("abort_q", 64'(q), 64'(0));
        chk("abort_r", 64'(r), 64'(0));
        chk("abort_dz", 64'(z), 64'(0));
        reset8 = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'(0));

        // First start right after reset release is accepted on the first edge.
        reset8 = 1'b1;
        tick();
        reset8 = 1'b0;
        run_op('{1, 0, 32'd9, 32'd2, 32'd4, 32'd1, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand, quotient and remainder width; legal values are 4..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; SHALL be sampled only in IDLE or DONE.
REQ-005 is_signed  input  1  0 selects unsigned division, 1 selects two's-complement division; SHALL be sampled with start.
REQ-006 dividend  input  WIDTH  numerator; SHALL be sampled with start.
REQ-007 divisor  input  WIDTH  denominator; SHALL be sampled with start.
REQ-008 busy  output  1  high while an operation is in flight.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 div_by_zero  output  1  status of the last result; held with that result.
REQ-011 quotient  output  WIDTH  registered quotient; held until the next done.
REQ-012 remainder  output  WIDTH  registered remainder; held until the next done.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC, FIX and DONE.
REQ-014 IDLE/DONE + start: operands are captured and the FSM goes to CALC; if divisor==0 it goes directly to DONE instead.
REQ-015 Capture SHALL store the operand magnitudes, negating negative operands only when is_signed=1.
REQ-016 Capture SHALL store the sign of the quotient (dividend sign XOR divisor sign) and the sign of the remainder (dividend sign).
REQ-017 Capture SHALL load the iteration counter with WIDTH-1.
REQ-018 CALC SHALL perform one restoring iteration per cycle:
  - shift the partial remainder left by one;
  - bring in the next dividend MSB;
  - trial-subtract the divisor using a WIDTH+1-bit subtract;
  - keep the difference and shift in quotient bit 1 if it is non-negative, otherwise restore and shift in 0.
REQ-019 CALC SHALL last exactly WIDTH cycles, then move to FIX.
REQ-020 FIX SHALL negate the quotient and/or remainder per the captured signs, register quotient/remainder, and move to DONE.
REQ-021 Latency: done SHALL assert WIDTH+2 cycles after the start-sampling edge (34 cycles for WIDTH=32).
REQ-022 done SHALL be high for exactly one cycle (entry into DONE).
REQ-023 The FSM SHALL leave DONE for IDLE on the next cycle unless start is high.
REQ-024 busy SHALL be high from the cycle after start is sampled until the cycle done rises, then low.
REQ-025 start while busy SHALL be ignored; the operands in flight are unaffected.
REQ-026 start in the done cycle SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-027 divisor==0 SHALL produce done on the cycle after start, with:
  - div_by_zero=1;
  - quotient = all ones;
  - remainder = dividend unchanged (both modes).
REQ-028 Signed dividend=minimum value (100...0) with divisor = -1 SHALL produce:
  - quotient = minimum value;
  - remainder = 0;
  - div_by_zero=0;
  - no other flag.
REQ-029 Signed results SHALL truncate toward zero; a nonzero remainder SHALL take the sign of the dividend.
REQ-030 The identity dividend == quotient*divisor + remainder SHALL hold modulo 2^WIDTH for every non-zero divisor.
REQ-031 Operand magnitudes SHALL be held as WIDTH-bit unsigned values, so the minimum-value magnitude 2^(WIDTH-1) is representable.

Reset
REQ-032 Reset SHALL force:
  - FSM to IDLE;
  - busy=0, done=0, div_by_zero=0;
  - quotient=0, remainder=0;
  - counter and internal registers cleared.
REQ-033 Reset SHALL take priority over start and over any state.
REQ-034 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-035 After reset deasserts, the first start SHALL be accepted on the first clk edge.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
  - WIDTH=32 unsigned 100/7 -> quotient=14, remainder=2, done exactly 34 cycles after start, busy high for 33 cycles.
  - WIDTH=32 signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
  - WIDTH=32 0x12345678/0 in either mode -> done one cycle after start, div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x12345678.
  - WIDTH=32 signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
  - Start 50/5, then pulse start with 9/3 at cycle 10 -> ignored; result quotient=10, remainder=0; start held in the done cycle -> 9/3 runs back-to-back giving quotient=3, remainder=0.
  - WIDTH=8 unsigned 0xFF/0x01 -> quotient=0xFF, remainder=0 in 10 cycles; reset asserted at cycle 4 -> busy=0, no done pulse, outputs=0.
